// File: rtl/discount_factor_ctrl_pkg.sv
// Shared definitions for the discounted-strike sequencer.
// Contents:
//   Q_FRAC    - fractional bits of the Q16.16 format
//   ONE       - 1.0 in Q16.16
//   X_MAX_DEF - default clamp ceiling for the exponent argument (4.0)
//   state_t   - sequencer states
package discount_factor_ctrl_pkg;

  localparam int Q_FRAC = 16;
  localparam logic signed [31:0] ONE       = 32'sh0001_0000;
  localparam logic signed [31:0] X_MAX_DEF = 32'sh0004_0000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_RT   = 3'd1,
    LAUNCH   = 3'd2,
    WAIT_EXP = 3'd3,
    MUL_K    = 3'd4,
    OUT      = 3'd5
  } state_t;

endpackage

// File: rtl/discount_factor_ctrl_qmul.sv
// qmul_q16: combinational signed fixed-point multiply.
// Forms the full 2*WIDTH-bit product of two Q16.16 operands and returns the
// Q16.16 slice (truncated toward minus infinity, no rounding) plus a flag
// that is set when the product does not fit the WIDTH-bit result.
// Ports:
//   a, b - signed operands, Q16.16
//   p    - (a*b)[WIDTH+15:16]
//   ovf  - upper product bits are not a sign extension of p
module qmul_q16
  import discount_factor_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p,
  output logic                    ovf
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shifted;

  assign prod    = a * b;
  assign shifted = prod >>> Q_FRAC;
  assign p       = shifted[WIDTH-1:0];

  // Result fits only if everything above p's sign bit repeats that sign bit.
  assign ovf = !((&shifted[2*WIDTH-1:WIDTH-1]) || !(|shifted[2*WIDTH-1:WIDTH-1]));

endmodule

// File: rtl/discount_factor_ctrl.sv
// discount_factor_ctrl: sequences the discounted-strike computation
// K * e^(-r*T). Accepts (r, t, k), forms x = r*t (clamped to X_MAX),
// launches an external exponent unit with a one-cycle start pulse, waits
// (bounded by TIMEOUT) for its result, multiplies k by it and presents the
// result until accepted.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   in_valid/in_ready       - input handshake; in_ready high only in IDLE
//   r, t, k                 - rate, time to expiry, strike (Q16.16 signed)
//   exp_start, exp_x        - launch pulse and argument to the exponent unit
//   exp_y, exp_done         - e^(-x) result and its one-cycle valid
//   out_valid/out_ready     - output handshake
//   pv_k, disc              - K*e^(-rT) and e^(-rT)
//   clamped, err            - x saturated; negative input or exponent timeout
module discount_factor_ctrl
  import discount_factor_ctrl_pkg::*;
#(
  parameter int                     WIDTH   = 32,
  parameter logic signed [WIDTH-1:0] X_MAX  = X_MAX_DEF,
  parameter int                     TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] r,
  input  logic signed [WIDTH-1:0] t,
  input  logic signed [WIDTH-1:0] k,
  output logic                    exp_start,
  output logic signed [WIDTH-1:0] exp_x,
  input  logic signed [WIDTH-1:0] exp_y,
  input  logic                    exp_done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] pv_k,
  output logic signed [WIDTH-1:0] disc,
  output logic                    clamped,
  output logic                    err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                  state;
  logic signed [WIDTH-1:0] r_p0, t_p0, k_p0;
  logic [CNT_W-1:0]        cnt;
  logic signed [WIDTH-1:0] x_raw, pv_raw;
  logic                    rt_ovf, pv_ovf_unused;
  logic                    accept, in_neg, clamp_need;

  function automatic logic signed [WIDTH-1:0] sat_x(input logic signed [WIDTH-1:0] x,
                                                    input logic ovf);
    if (ovf || (x > X_MAX)) return X_MAX;
    return x;
  endfunction

  assign accept     = (state == IDLE) && in_valid && in_ready;
  assign in_neg     = r_p0[WIDTH-1] | t_p0[WIDTH-1];
  assign clamp_need = rt_ovf || (x_raw > X_MAX);

  qmul_q16 #(.WIDTH(WIDTH)) u_mul_rt (.a(r_p0), .b(t_p0), .p(x_raw),  .ovf(rt_ovf));
  // The final product is truncated as-is; its overflow flag is not used.
  qmul_q16 #(.WIDTH(WIDTH)) u_mul_k  (.a(k_p0), .b(disc), .p(pv_raw), .ovf(pv_ovf_unused));

  // Stage p0: operand capture at accept (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      r_p0 <= r;
      t_p0 <= t;
      k_p0 <= k;
    end
  end

  // Sequencer: all outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      exp_start <= 1'b0;
      exp_x     <= '0;
      out_valid <= 1'b0;
      pv_k      <= '0;
      disc      <= '0;
      clamped   <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            clamped  <= 1'b0;
            err      <= 1'b0;
            state    <= MUL_RT;
          end else begin
            in_ready <= 1'b1;
          end
        end
        MUL_RT: begin
          if (in_neg) begin
            err       <= 1'b1;
            disc      <= '0;
            pv_k      <= '0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            exp_x     <= sat_x(x_raw, rt_ovf);
            clamped   <= clamp_need;
            exp_start <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          exp_start <= 1'b0;
          cnt       <= '0;
          state     <= WAIT_EXP;
        end
        WAIT_EXP: begin
          // A done arriving in the final allowed cycle still counts.
          if (exp_done) begin
            disc  <= exp_y;
            state <= MUL_K;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            err       <= 1'b1;
            disc      <= '0;
            pv_k      <= '0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MUL_K: begin
          pv_k      <= pv_raw;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/discount_factor_ctrl.md
# discount_factor_ctrl

Upstream sequencing stage of the Black-Scholes datapath that produces the discounted strike K·e^(−rT). It accepts (r, T, K) on a valid/ready handshake and forms the exponent x = r·T in Q16.16. It then launches the exponent unit with a single-cycle start pulse and waits for its done flag. Finally it multiplies K by the returned e^(−x) and presents the result on a valid/ready output.

## Interface
- WIDTH, 32: datapath width, Q16.16 signed
- X_MAX, 32'h0004_0000: clamp ceiling for x (4.0), above which the series is not trusted
- TIMEOUT, 64: max cycles to wait for exp_done after exp_start
- clk  in  1  clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  r/T/K valid
- in_ready  out  1  block can accept (high only in IDLE)
- r  in  WIDTH  risk-free rate, Q16.16 signed
- t  in  WIDTH  time to expiry (years), Q16.16 signed
- k  in  WIDTH  strike, Q16.16 signed
- exp_start  out  1  one-cycle launch pulse to exponent unit
- exp_x  out  WIDTH  exponent x, held stable from launch until exp_done or timeout
- exp_y  in  WIDTH  e^(−x) from exponent unit, Q16.16
- exp_done  in  1  exponent result valid (one cycle)
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts
- pv_k  out  WIDTH  K·e^(−rT), Q16.16
- disc  out  WIDTH  e^(−rT) as returned
- clamped  out  1  x was saturated to X_MAX
- err  out  1  negative input or exponent timeout

## Operation
- States: IDLE, MUL_RT, LAUNCH, WAIT_EXP, MUL_K, OUT.
- IDLE: in_ready=1. On in_valid, latch r, t and k, clear flags, go to MUL_RT.
- MUL_RT: compute prod = r·t as a 64-bit signed product; x = prod[47:16].
  - If r<0 or t<0: set err, force disc=0 and pv_k=0, go to OUT without launching.
  - Else if prod[63:47] is not all zero, or x > X_MAX: x = X_MAX and clamped=1.
  - Otherwise go to LAUNCH.
- LAUNCH: exp_start=1 for exactly this cycle, exp_x=x. Clear the timeout counter. Go to WAIT_EXP.
- WAIT_EXP: exp_start=0. The counter increments each cycle.
  - On exp_done: capture disc=exp_y and go to MUL_K.
  - If the counter reaches TIMEOUT first: err=1, disc=0, pv_k=0, go to OUT.
- MUL_K: pv_k = (k·disc)[47:16] from a 64-bit signed product, truncated with no rounding. Go to OUT.
- OUT: out_valid=1 with pv_k, disc, clamped and err stable. When out_ready is high, go to IDLE.
- exp_done outside WAIT_EXP is ignored.
- exp_x holds its last value at all times, so it is never X while the exponent unit samples it.

## Timing
- Reset values: in_ready=0 during reset and 1 after it. exp_start=0, exp_x=0, out_valid=0, pv_k=0, disc=0, clamped=0, err=0. State is IDLE.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs at their reset values. No exp_start is issued after reset deasserts unless a new input is accepted.
- Accept to exp_start is 2 cycles (accept edge, MUL_RT, LAUNCH).
- exp_done to out_valid is 2 cycles (capture edge, MUL_K).
- The path with the 10-cycle exponent unit is 14 cycles from accept to out_valid.
- exp_start is high for exactly 1 cycle per accepted transaction, which guarantees a fresh rising edge at the exponent unit.
- Back-to-back: in_ready returns the cycle after the out_valid&&out_ready handshake. Throughput is one transaction per (latency+1) cycles.
- out_ready held low: out_valid and the data hold indefinitely, and no new input is accepted.
- exp_done in the same cycle the counter hits TIMEOUT: exp_done wins and err stays 0.

## Structure
- A shared package holds the Q16.16 constants (ONE, X_MAX default) and the state enum.
- Sub-module qmul_q16 (signed 64-bit multiply, returns [47:16] plus an overflow flag) is used for both multiplies. It is also intended for reuse by other stages.
- The exponent unit is not instantiated here; the parent wires it.

## Test plan
- r=0x0000_0CCC (0.05), t=0x0001_0000, k=0x0064_0000, exp model returns 0x0000_F383 after 10 cycles.
  - Required: exp_x=0x0000_0CCC, exactly one exp_start pulse.
  - Required: pv_k=0x005F_1F2C, disc=0x0000_F383, err=0, clamped=0, out_valid 14 cycles after accept.
- r=0x0002_0000, t=0x0003_0000: exp_x=0x0004_0000 and clamped=1.
- r=0xFFFF_0000 (−1.0): no exp_start, out_valid 2 cycles after accept, err=1, pv_k=0.
- Exp model never asserts done: out_valid at TIMEOUT+3 cycles after accept, with err=1 and pv_k=0.
- out_ready low for 5 cycles, then a second input queued: outputs stable throughout, in_ready=0 until the handshake, second transaction correct.
- reset_n pulsed low during WAIT_EXP, then a late exp_done: all outputs 0, state IDLE, late done ignored, next transaction correct.
